// File: rtl/iter_multiplier.sv
// Iterative 32x32 shift-add multiplier (signed/unsigned). It takes 34 cycles per product
// and emits a one-cycle WE pulse so the downstream HI/LO registers load the result.
module iter_multiplier (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        SIGNED,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        BUSY,
    output logic        WE,
    output logic [31:0] DataLo,
    output logic [31:0] DataHi,
    output logic        OVF
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_WRITE} state_t;

    state_t      r_state;
    logic        r_busy;
    logic        r_we;
    logic [31:0] r_data_lo;
    logic [31:0] r_data_hi;
    logic        r_ovf;
    logic [4:0]  r_cnt;
    logic [63:0] r_p;
    logic [31:0] r_m;
    logic        r_neg;
    logic        r_signed;

    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_t;
    logic [63:0] w_p_next;
    logic [63:0] w_r;
    logic        w_ovf;

    // Magnitudes are taken as 32-bit unsigned, so |0x80000000| stays 0x80000000.
    assign w_mag_a  = (SIGNED && A[31]) ? (~A + 32'd1) : A;
    assign w_mag_b  = (SIGNED && B[31]) ? (~B + 32'd1) : B;

    assign w_t      = {1'b0, r_p[63:32]} + (r_p[0] ? {1'b0, r_m} : 33'd0);
    assign w_p_next = {w_t, r_p[31:1]};
    assign w_r      = r_neg ? (~w_p_next + 64'd1) : w_p_next;
    assign w_ovf    = r_signed ? (w_r[63:32] != {32{w_r[31]}}) : (w_r[63:32] != 32'h0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_we      <= 1'b0;
            r_data_lo <= 32'h0;
            r_data_hi <= 32'h0;
            r_ovf     <= 1'b0;
            r_cnt     <= 5'd0;
            r_p       <= 64'h0;
            r_m       <= 32'h0;
            r_neg     <= 1'b0;
            r_signed  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_state  <= S_BUSY;
                        r_busy   <= 1'b1;
                        r_neg    <= SIGNED & (A[31] ^ B[31]);
                        r_signed <= SIGNED;
                        r_m      <= w_mag_a;
                        r_p      <= {32'h0, w_mag_b};
                        r_cnt    <= 5'd0;
                    end
                end
                S_BUSY: begin
                    r_p   <= w_p_next;
                    r_cnt <= r_cnt + 5'd1;
                    // The last iteration's sum feeds the output registers directly.
                    if (r_cnt == 5'd31) begin
                        r_state   <= S_WRITE;
                        r_we      <= 1'b1;
                        r_data_lo <= w_r[31:0];
                        r_data_hi <= w_r[63:32];
                        r_ovf     <= w_ovf;
                    end
                end
                S_WRITE: begin
                    r_state <= S_IDLE;
                    r_we    <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_we    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY   = r_busy;
    assign WE     = r_we;
    assign DataLo = r_data_lo;
    assign DataHi = r_data_hi;
    assign OVF    = r_ovf;
endmodule

// File: tb/tb_iter_multiplier.sv
// Bench for iter_multiplier: an arithmetic/timing reference model is checked on every
// negative edge, and hand-computed literal results are checked for directed operand pairs.
module tb_iter_multiplier;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        sgn = 1'b0;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic        busy;
    logic        we;
    logic [31:0] data_lo;
    logic [31:0] data_hi;
    logic        ovf;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    iter_multiplier dut (
        .CLK    (clk),
        .RST    (rst),
        .START  (start),
        .SIGNED (sgn),
        .A      (a),
        .B      (b),
        .BUSY   (busy),
        .WE     (we),
        .DataLo (data_lo),
        .DataHi (data_hi),
        .OVF    (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference result: {ovf, product} from plain 64-bit arithmetic.
    function automatic logic [64:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic signed [63:0] sp;
        logic [63:0]        up;
        logic               o;
        if (s) begin
            sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
            o  = (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
            return {o, sp};
        end
        up = {32'h0, x} * {32'h0, y};
        o  = (up[63:32] != 32'h0);
        return {o, up};
    endfunction

    // Timing model: ph counts edges since acceptance (1 after E0 .. 33 after E32).
    int          m_ph = 0;
    logic [64:0] m_pend = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] m_hi = '0;
    logic        m_ovf = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph  <= 0;
            m_lo  <= '0;
            m_hi  <= '0;
            m_ovf <= 1'b0;
        end else if (m_ph == 0) begin
            if (start) begin
                m_ph   <= 1;
                m_pend <= ref_mul(a, b, sgn);
            end
        end else if (m_ph == 32) begin
            m_ph  <= 33;
            m_lo  <= m_pend[31:0];
            m_hi  <= m_pend[63:32];
            m_ovf <= m_pend[64];
        end else if (m_ph == 33) begin
            m_ph <= 0;
        end else begin
            m_ph <= m_ph + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_busy", 64'(busy), 64'(m_ph != 0));
            chk("model_we", 64'(we), 64'(m_ph == 33));
            chk("model_lo", 64'(data_lo), 64'(m_lo));
            chk("model_hi", 64'(data_hi), 64'(m_hi));
            chk("model_ovf", 64'(ovf), 64'(m_ovf));
        end
    end

    task automatic wait_we(input string nm, input int exp_lat);
        int n;
        n = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (we) begin
                n = k;
                break;
            end
        end
        chk({nm, "_latency"}, 64'(n), 64'(exp_lat));
    endtask

    task automatic run_op(input string nm, input logic [31:0] x, input logic [31:0] y, input logic s,
                          input logic [31:0] eh, input logic [31:0] el, input logic eo);
        @(negedge clk);
        a = x; b = y; sgn = s; start = 1'b1;
        wait_we(nm, 33);
        chk({nm, "_hi"}, 64'(data_hi), 64'(eh));
        chk({nm, "_lo"}, 64'(data_lo), 64'(el));
        chk({nm, "_ovf"}, 64'(ovf), 64'(eo));
        @(negedge clk);
        chk({nm, "_we_after"}, 64'(we), 64'd0);
        chk({nm, "_busy_after"}, 64'(busy), 64'd0);
        $display("op %s a=%h b=%h s=%0d -> hi=%h lo=%h ovf=%0d", nm, x, y, s, data_hi, data_lo, ovf);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_we", 64'(we), 64'd0);
        chk("reset_data", {data_hi, data_lo}, 64'd0);
        chk("reset_ovf", 64'(ovf), 64'd0);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        run_op("u7x6",     32'd7,          32'd6,          1'b0, 32'h0,        32'd42,       1'b0);
        run_op("uffxff",   32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 32'hFFFFFFFE, 32'h00000001, 1'b1);
        run_op("s-3x5",    32'hFFFFFFFD,   32'd5,          1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        run_op("s80x80",   32'h80000000,   32'h80000000,   1'b1, 32'h40000000, 32'h0,        1'b1);
        run_op("s0x-5",    32'h0,          32'hFFFFFFFB,   1'b1, 32'h0,        32'h0,        1'b0);
        run_op("s80x1",    32'h80000000,   32'd1,          1'b1, 32'hFFFFFFFF, 32'h80000000, 1'b0);
        run_op("s-1x80",   32'hFFFFFFFF,   32'h80000000,   1'b1, 32'h0,        32'h80000000, 1'b1);
        run_op("u10kx10k", 32'h00010000,   32'h00010000,   1'b0, 32'h1,        32'h0,        1'b1);

        // START held and operands scrambled while busy; back-to-back second product.
        @(negedge clk);
        a = 32'd100; b = 32'd200; sgn = 1'b0; start = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (k < 33) begin
                a = $urandom; b = $urandom; sgn = 1'($urandom_range(0, 1));
            end
        end
        chk("hold_we", 64'(we), 64'd1);
        chk("hold_lo", 64'(data_lo), 64'd20000);
        chk("hold_hi", 64'(data_hi), 64'd0);
        a = 32'd9; b = 32'd11; sgn = 1'b0;
        @(negedge clk);
        chk("hold_e33_busy", 64'(busy), 64'd0);
        chk("hold_e33_we", 64'(we), 64'd0);
        @(negedge clk);
        chk("hold_e34_busy", 64'(busy), 64'd1);
        start = 1'b0;
        wait_we("hold2", 32);
        chk("hold2_lo", 64'(data_lo), 64'd99);
        $display("op hold2 -> hi=%h lo=%h ovf=%0d", data_hi, data_lo, ovf);
        @(negedge clk);

        // Asynchronous reset after E10 of an operation.
        @(negedge clk);
        a = 32'd123; b = 32'd456; sgn = 1'b0; start = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_we", 64'(we), 64'd0);
        chk("rst_mid_data", {data_hi, data_lo}, 64'd0);
        chk("rst_mid_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (40) @(negedge clk);
        $display("op rst_mid -> busy=%0d hi=%h lo=%h", busy, data_hi, data_lo);
        run_op("u2x3", 32'd2, 32'd3, 1'b0, 32'h0, 32'd6, 1'b0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
